// File: rtl/br_update_queue.sv
// Branch update queue: holds predicted branches until execute resolves them,
// then retires them in order as predictor update records.
module br_update_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned HIST_BITS = 8,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned RES_PORTS = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        alloc_valid,
  output logic                                        alloc_ready,
  input  logic [ADDR_BITS-1:0]                        alloc_pc,
  input  logic [HIST_BITS-1:0]                        alloc_hist,
  input  logic [CTR_BITS-1:0]                         alloc_ctr,
  input  logic                                        alloc_pred_taken,
  output logic [$clog2(DEPTH)-1:0]                    alloc_tag,
  input  logic [RES_PORTS-1:0]                        res_valid,
  input  logic [RES_PORTS-1:0][$clog2(DEPTH)-1:0]     res_tag,
  input  logic [RES_PORTS-1:0]                        res_taken,
  input  logic [RES_PORTS-1:0]                        res_is_cond,
  input  logic [RES_PORTS-1:0]                        res_tgt_mispred,
  output logic [RES_PORTS-1:0]                        upd_valid,
  output logic [RES_PORTS-1:0][ADDR_BITS-1:0]         upd_addr,
  output logic [RES_PORTS-1:0][HIST_BITS-1:0]         upd_hist,
  output logic [RES_PORTS-1:0][CTR_BITS-1:0]          upd_ctr,
  output logic [RES_PORTS-1:0]                        upd_exec_taken,
  output logic [RES_PORTS-1:0]                        upd_is_cond,
  output logic [RES_PORTS-1:0]                        upd_mispred,
  output logic                                        flush
);
  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     resolved;
  logic [ADDR_BITS-1:0] pc_q    [DEPTH];
  logic [HIST_BITS-1:0] hist_q  [DEPTH];
  logic [CTR_BITS-1:0]  ctr_q   [DEPTH];
  logic [DEPTH-1:0]     pred_q;
  logic [DEPTH-1:0]     taken_q;
  logic [DEPTH-1:0]     cond_q;
  logic [DEPTH-1:0]     misp_q;

  logic [TAG_W-1:0]     head;
  logic [TAG_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 live;

  logic [RES_PORTS-1:0]            ret;
  logic [RES_PORTS-1:0][TAG_W-1:0] ret_idx;
  logic [CNT_W-1:0]                n_ret;
  logic                            flush_now;
  logic [TAG_W-1:0]                flush_idx;
  logic                            chain;
  logic [RES_PORTS-1:0]            res_apply;
  logic                            alloc_fire;

  // In-order retire: the chain breaks at the first non-retirable entry or
  // right after a mispredicted one, which also triggers the flush.
  always_comb begin
    ret       = '0;
    ret_idx   = '0;
    n_ret     = '0;
    flush_now = 1'b0;
    flush_idx = '0;
    chain     = 1'b1;
    for (int unsigned k = 0; k < RES_PORTS; k++) begin
      ret_idx[k] = head + TAG_W'(k);
      if (chain && valid[ret_idx[k]] && resolved[ret_idx[k]]) begin
        ret[k] = 1'b1;
        n_ret  = n_ret + CNT_W'(1);
        if (misp_q[ret_idx[k]]) begin
          flush_now = 1'b1;
          flush_idx = ret_idx[k];
          chain     = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // A flush retires or invalidates every valid entry, so all resolves that
  // cycle are dropped; lower-numbered ports shadow higher ones on a tag clash.
  always_comb begin
    res_apply = '0;
    for (int unsigned p = 0; p < RES_PORTS; p++) begin
      res_apply[p] = res_valid[p] && valid[res_tag[p]] && !resolved[res_tag[p]] && !flush_now;
      for (int unsigned q = 0; q < p; q++) begin
        if (res_valid[q] && (res_tag[q] == res_tag[p])) res_apply[p] = 1'b0;
      end
    end
  end

  assign alloc_ready = live && (count < CNT_W'(DEPTH)) && !flush_now;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      resolved <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      head <= head + n_ret[TAG_W-1:0];
      if (flush_now) begin
        valid <= '0;
        tail  <= flush_idx + TAG_W'(1);
        count <= '0;
      end else begin
        tail  <= tail + TAG_W'(alloc_fire);
        count <= count + CNT_W'(alloc_fire) - n_ret;
        for (int unsigned k = 0; k < RES_PORTS; k++) begin
          if (ret[k]) valid[ret_idx[k]] <= 1'b0;
        end
        for (int unsigned p = 0; p < RES_PORTS; p++) begin
          if (res_apply[p]) resolved[res_tag[p]] <= 1'b1;
        end
        if (alloc_fire) begin
          valid[tail]    <= 1'b1;
          resolved[tail] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail]   <= alloc_pc;
      hist_q[tail] <= alloc_hist;
      ctr_q[tail]  <= alloc_ctr;
      pred_q[tail] <= alloc_pred_taken;
    end
    for (int unsigned p = 0; p < RES_PORTS; p++) begin
      if (res_apply[p]) begin
        taken_q[res_tag[p]] <= res_taken[p];
        cond_q[res_tag[p]]  <= res_is_cond[p];
        misp_q[res_tag[p]]  <= res_is_cond[p] ? (res_taken[p] != pred_q[res_tag[p]])
                                              : res_tgt_mispred[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid      <= '0;
      upd_addr       <= '0;
      upd_hist       <= '0;
      upd_ctr        <= '0;
      upd_exec_taken <= '0;
      upd_is_cond    <= '0;
      upd_mispred    <= '0;
      flush          <= 1'b0;
    end else begin
      flush <= flush_now;
      for (int unsigned k = 0; k < RES_PORTS; k++) begin
        upd_valid[k]      <= ret[k];
        upd_addr[k]       <= ret[k] ? pc_q[ret_idx[k]]   : '0;
        upd_hist[k]       <= ret[k] ? hist_q[ret_idx[k]] : '0;
        upd_ctr[k]        <= ret[k] ? ctr_q[ret_idx[k]]  : '0;
        upd_exec_taken[k] <= ret[k] && taken_q[ret_idx[k]];
        upd_is_cond[k]    <= ret[k] && cond_q[ret_idx[k]];
        upd_mispred[k]    <= ret[k] && misp_q[ret_idx[k]];
      end
    end
  end

endmodule
